dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;
    localparam int DW = 16;   // data word width
    localparam int CW = 4;    // wait-counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Request attributes latched at the request handshake
    typedef struct packed {
        logic we;
        logic err;
    } req_t;

    // Misaligned byte address, or word index beyond the array
    function automatic logic addr_err(input logic [15:0] addr, input int unsigned depth);
        return addr[0] || ({17'b0, addr[15:1]} >= depth);
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// CPU-side load/store request and response channel of the data memory.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [15:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word storage: combinational read, synchronous write, never cleared by reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: IDLE -> (WAIT) -> RESP -> IDLE.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states; otherwise every access takes 1 cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clock,
    input logic             reset_n,
    dmem_responder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_WAIT_EN
    localparam bit            DIRECT    = (WAIT_CYCLES == 0);
    localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);
`else
    localparam bit            DIRECT    = 1'b1;
`endif

    state_e        state_q, state_d;
    req_t          req_q, req_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          hs_req, in_err, wr_en;
    logic [AW-1:0] in_idx, wr_idx;
    logic [DW-1:0] wr_data, rd_data;
`ifdef DMEM_WAIT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] wdata_q, wdata_d;
`endif

    assign in_err = addr_err(bus.req_addr, DEPTH);
    assign in_idx = bus.req_addr[AW:1];
    assign hs_req = bus.req_valid && bus.req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            idx_q   <= '0;
`ifdef DMEM_WAIT_EN
            cnt_q   <= '0;
            wdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
`ifdef DMEM_WAIT_EN
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        idx_d   = idx_q;
`ifdef DMEM_WAIT_EN
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
`endif
        case (state_q)
            IDLE: if (hs_req) begin
                req_d = '{we: bus.req_we, err: in_err};
                idx_d = in_idx;
`ifdef DMEM_WAIT_EN
                wdata_d = bus.req_wdata;
                if (DIRECT) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                end
`else
                state_d = RESP;
`endif
            end
`ifdef DMEM_WAIT_EN
            WAIT: if (cnt_q == CW'(1)) begin
                state_d = RESP;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
`endif
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The single commit point of a store is the transition into RESP
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = idx_q;
`ifdef DMEM_WAIT_EN
        wr_data = wdata_q;
        if (state_q == WAIT && cnt_q == CW'(1)) wr_en = req_q.we && !req_q.err;
`else
        wr_data = bus.req_wdata;
`endif
        if (state_q == IDLE && hs_req && DIRECT) begin
            wr_en   = bus.req_we && !in_err;
            wr_idx  = in_idx;
            wr_data = bus.req_wdata;
        end
    end

    // reset_n gating keeps req_ready low for the whole reset window
    assign bus.req_ready = (state_q == IDLE) && reset_n;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && req_q.err;
    assign bus.rsp_rdata = (state_q == RESP && !req_q.we && !req_q.err) ? rd_data : '0;

    dmem_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_array (
        .clock  (clock),
        .we_i   (wr_en),
        .waddr_i(wr_idx),
        .wdata_i(wr_data),
        .raddr_i(idx_q),
        .rdata_o(rd_data)
    );
endmodule
